if_fetch_icache: RTL and testbench

- Instruction-fetch stage directly upstream of the memory controller's instruction port. It feeds the decode/issue stage.
- Holds the PC and a direct-mapped instruction cache.
- On a hit, it delivers the instruction from the cache. On a miss, it issues a 4-byte read to the memory controller (if_read_or_not / intru_addr), fills the cache, and forwards the word downstream.
- Accepts redirects (jumps) from the execute stage.

---
 rtl/if_fetch_icache.sv | 162 ++++++++++++++++
 tb/tb_if_fetch_icache.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_icache.sv
// Instruction-fetch stage: PC, direct-mapped one-word-line icache, miss path to memctrl.
// Cache storage exists only when IF_ICACHE_EN is defined; otherwise every fetch misses.
module if_fetch_icache #(
  parameter int unsigned ICACHE_ENTRIES = 64,
  parameter int unsigned INDEX_W        = 6,
  parameter logic [31:0] RESET_PC       = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        stall_in,
  input  logic        jump_in,
  input  logic [31:0] jump_addr_in,
  output logic        inst_valid_out,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc_out,
  output logic        if_read_or_not,
  output logic [31:0] intru_addr,
  input  logic        if_load_done,
  input  logic [31:0] mem_ctrl_instru_to_if
);

  typedef enum logic {S_FETCH, S_MISS_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic        vld_q, vld_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;

  logic        hit;
  logic [31:0] hit_data;
  logic        fill;
  logic        slot_busy;
  logic [31:0] jump_target;

  if ((ICACHE_ENTRIES != (32'd1 << INDEX_W)) || (INDEX_W < 1) || (INDEX_W > 29)) begin : g_bad_cfg
    $error("if_fetch_icache: ICACHE_ENTRIES must equal 2**INDEX_W with 1 <= INDEX_W <= 29");
  end

  assign jump_target = {jump_addr_in[31:2], 2'b00};
  assign slot_busy   = vld_q && stall_in;
  assign fill        = rdy_in && (state_q == S_MISS_WAIT) && if_load_done;

`ifdef IF_ICACHE_EN
  localparam int unsigned TAG_W = 30 - INDEX_W;

  logic [ICACHE_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]          tag_q  [ICACHE_ENTRIES];
  logic [31:0]               data_q [ICACHE_ENTRIES];
  logic [INDEX_W-1:0]        rd_idx;
  logic [INDEX_W-1:0]        wr_idx;

  // Fills index by the outstanding request address; pc may already point at a jump target.
  assign rd_idx   = pc_q[INDEX_W+1:2];
  assign wr_idx   = addr_q[INDEX_W+1:2];
  assign hit      = valid_q[rd_idx] && (tag_q[rd_idx] == pc_q[31:INDEX_W+2]);
  assign hit_data = data_q[rd_idx];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (fill) begin
      tag_q[wr_idx]  <= addr_q[31:INDEX_W+2];
      data_q[wr_idx] <= mem_ctrl_instru_to_if;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    vld_d     = vld_q;
    inst_d    = inst_q;
    ipc_d     = ipc_q;
    req_d     = req_q;
    addr_d    = addr_q;
    if (rdy_in) begin
      if (vld_q && !stall_in) vld_d = 1'b0;
      case (state_q)
        S_FETCH: begin
          if (jump_in) begin
            pc_d = jump_target;
          end else if (!slot_busy) begin
            if (hit) begin
              vld_d  = 1'b1;
              inst_d = hit_data;
              ipc_d  = pc_q;
              pc_d   = pc_q + 32'd4;
            end else begin
              req_d   = 1'b1;
              addr_d  = pc_q;
              state_d = S_MISS_WAIT;
            end
          end
        end
        S_MISS_WAIT: begin
          // The output slot is always empty here, so a non-discarded fill emits directly.
          if (if_load_done) begin
            req_d     = 1'b0;
            state_d   = S_FETCH;
            discard_d = 1'b0;
            if (jump_in) begin
              pc_d = jump_target;
            end else if (!discard_q) begin
              vld_d  = 1'b1;
              inst_d = mem_ctrl_instru_to_if;
              ipc_d  = pc_q;
              pc_d   = pc_q + 32'd4;
            end
          end else if (jump_in) begin
            pc_d      = jump_target;
            discard_d = 1'b1;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      vld_q     <= 1'b0;
      inst_q    <= '0;
      ipc_q     <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      vld_q     <= vld_d;
      inst_q    <= inst_d;
      ipc_q     <= ipc_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
    end
  end

  assign inst_valid_out = vld_q;
  assign inst_out       = inst_q;
  assign inst_pc_out    = ipc_q;
  assign if_read_or_not = req_q;
  assign intru_addr     = addr_q;

endmodule

// File: tb/tb_if_fetch_icache.sv
// Directed bench for if_fetch_icache: per-cycle vector table plus hand sequences for hits,
// stalls and reset mid-miss. Memory word at address a is modelled as (a << 8) | 0x93.
module tb_if_fetch_icache;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        stall;
  logic        jump;
  logic [31:0] jaddr;
  logic        inst_valid_out;
  logic [31:0] inst_out;
  logic [31:0] inst_pc_out;
  logic        if_read_or_not;
  logic [31:0] intru_addr;
  logic        load_done;
  logic [31:0] mem_data;

  int n_checks = 0;
  int n_errors = 0;

  if_fetch_icache dut (
    .clk_in                (clk),
    .rst_in                (rst_n),
    .rdy_in                (rdy),
    .stall_in              (stall),
    .jump_in               (jump),
    .jump_addr_in          (jaddr),
    .inst_valid_out        (inst_valid_out),
    .inst_out              (inst_out),
    .inst_pc_out           (inst_pc_out),
    .if_read_or_not        (if_read_or_not),
    .intru_addr            (intru_addr),
    .if_load_done          (load_done),
    .mem_ctrl_instru_to_if (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        stall;
    logic        jump;
    logic [31:0] jaddr;
    logic        done;
    logic [31:0] data;
    logic        evld;
    logic [31:0] einst;
    logic [31:0] epc;
    logic        ereq;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic s, input logic j, input logic [31:0] ja,
                              input logic d, input logic [31:0] dat, input logic ev,
                              input logic [31:0] ei, input logic [31:0] ep, input logic er,
                              input logic [31:0] ea);
    vec_t v;
    v.rdy = r; v.stall = s; v.jump = j; v.jaddr = ja; v.done = d; v.data = dat;
    v.evld = ev; v.einst = ei; v.epc = ep; v.ereq = er; v.eaddr = ea;
    return v;
  endfunction

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a << 8) | 32'h93;
  endfunction

  task automatic chk(input string name, input logic evld, input logic [31:0] einst,
                     input logic [31:0] epc, input logic ereq, input logic [31:0] eaddr,
                     input bit full);
    bit bad;
    n_checks++;
    bad = (inst_valid_out !== evld) || (if_read_or_not !== ereq) || (intru_addr !== eaddr);
    if (full || evld) bad = bad || (inst_out !== einst) || (inst_pc_out !== epc);
    if (bad) begin
      n_errors++;
      $display("FAIL %s: got vld=%0b inst=%h pc=%h req=%0b addr=%h, want vld=%0b inst=%h pc=%h req=%0b addr=%h",
               name, inst_valid_out, inst_out, inst_pc_out, if_read_or_not, intru_addr,
               evld, einst, epc, ereq, eaddr);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic j, input logic [31:0] ja,
                      input logic d, input logic [31:0] dat);
    @(negedge clk);
    rdy = r; stall = s; jump = j; jaddr = ja; load_done = d; mem_data = dat;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; stall = 1'b0; jump = 1'b0; jaddr = '0;
    load_done = 1'b0; mem_data = '0;

    // Row: rdy stall jump jaddr done data | vld inst pc req addr
    tbl.push_back(mk(1,0,0,0,0,0,                    0,0,0,1,32'h0));
    tbl.push_back(mk(1,0,0,0,0,0,                    0,0,0,1,32'h0));
    tbl.push_back(mk(0,0,0,0,0,0,                    0,0,0,1,32'h0));
    tbl.push_back(mk(1,0,0,0,1,32'h93,               1,32'h93,32'h0,0,32'h0));
    tbl.push_back(mk(0,0,0,0,0,0,                    1,32'h93,32'h0,0,32'h0));
    tbl.push_back(mk(1,0,0,0,0,0,                    0,0,0,1,32'h4));
    tbl.push_back(mk(1,0,0,0,1,32'h493,              1,32'h493,32'h4,0,32'h4));
    tbl.push_back(mk(1,0,0,0,0,0,                    0,0,0,1,32'h8));
    tbl.push_back(mk(1,0,0,0,1,32'h893,              1,32'h893,32'h8,0,32'h8));
    tbl.push_back(mk(1,0,0,0,0,0,                    0,0,0,1,32'hC));
    tbl.push_back(mk(1,0,0,0,1,32'hC93,              1,32'hC93,32'hC,0,32'hC));
    tbl.push_back(mk(1,1,0,0,0,0,                    1,32'hC93,32'hC,0,32'hC));
    tbl.push_back(mk(1,1,0,0,1,32'hDEADBEEF,         1,32'hC93,32'hC,0,32'hC));
    tbl.push_back(mk(1,0,1,32'h40,0,0,               0,0,0,0,32'hC));
    tbl.push_back(mk(1,0,0,0,0,0,                    0,0,0,1,32'h40));
    tbl.push_back(mk(1,0,1,32'h103,0,0,              0,0,0,1,32'h40));
    tbl.push_back(mk(1,0,0,0,1,32'h4093,             0,0,0,0,32'h40));
    tbl.push_back(mk(1,0,0,0,0,0,                    0,0,0,1,32'h100));
    tbl.push_back(mk(1,0,0,0,1,32'h10093,            1,32'h10093,32'h100,0,32'h100));
    tbl.push_back(mk(1,0,1,32'h0,0,0,                0,0,0,0,32'h100));
    tbl.push_back(mk(1,0,0,0,0,0,                    0,0,0,1,32'h0));
    tbl.push_back(mk(1,0,0,0,1,32'h93,               1,32'h93,32'h0,0,32'h0));
    tbl.push_back(mk(1,0,1,32'h200,0,0,              0,0,0,0,32'h0));
    tbl.push_back(mk(1,0,0,0,0,0,                    0,0,0,1,32'h200));
    tbl.push_back(mk(1,0,1,32'h300,1,32'h20093,      0,0,0,0,32'h200));
    tbl.push_back(mk(1,0,0,0,0,0,                    0,0,0,1,32'h300));
    tbl.push_back(mk(1,0,0,0,1,32'h30093,            1,32'h30093,32'h300,0,32'h300));
    tbl.push_back(mk(1,0,1,32'hFFFFFFFF,0,0,         0,0,0,0,32'h300));
    tbl.push_back(mk(1,0,0,0,0,0,                    0,0,0,1,32'hFFFFFFFC));
    tbl.push_back(mk(1,0,0,0,1,32'hFFFFFC93,         1,32'hFFFFFC93,32'hFFFFFFFC,0,32'hFFFFFFFC));
    tbl.push_back(mk(1,0,0,0,0,0,                    0,0,0,1,32'h0));
    tbl.push_back(mk(1,0,0,0,1,32'h93,               1,32'h93,32'h0,0,32'h0));

    @(posedge clk);
    #1;
    chk("reset_state", 0, 32'h0, 32'h0, 0, 32'h0, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rdy, tbl[i].stall, tbl[i].jump, tbl[i].jaddr, tbl[i].done, tbl[i].data);
      chk($sformatf("vec%0d", i), tbl[i].evld, tbl[i].einst, tbl[i].epc, tbl[i].ereq,
          tbl[i].eaddr, 0);
    end

`ifdef IF_ICACHE_EN
    step(1,0,1,32'h0,0,0);
    chk("loop_jump", 0, 0, 0, 0, 32'h0, 0);
    for (int k = 0; k < 4; k++) begin
      step(1,0,0,0,0,0);
      chk($sformatf("loop_hit%0d", k), 1, word(32'(k*4)), 32'(k*4), 0, 32'h0, 0);
    end
    step(1,0,1,32'h0,0,0);
    chk("reloop_jump", 0, 0, 0, 0, 32'h0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1,0,0,0,0,0);
      chk($sformatf("reloop_hit%0d", k), 1, word(32'(k*4)), 32'(k*4), 0, 32'h0, 0);
    end
    for (int k = 0; k < 5; k++) begin
      step(1,1,0,0,0,0);
      chk($sformatf("stall_hold%0d", k), 1, 32'h893, 32'h8, 0, 32'h0, 0);
    end
    step(1,0,0,0,0,0);
    chk("stall_release", 1, 32'hC93, 32'hC, 0, 32'h0, 0);
    step(1,0,1,32'h40,0,0);
    chk("jump_40", 0, 0, 0, 0, 32'h0, 0);
    step(1,0,0,0,0,0);
    chk("hit_40_after_discard", 1, 32'h4093, 32'h40, 0, 32'h0, 0);
    step(1,0,1,32'h80,0,0);
    chk("jump_80", 0, 0, 0, 0, 32'h0, 0);
`else
    step(1,0,1,32'h0,0,0);
    chk("loop_jump", 0, 0, 0, 0, 32'h0, 0);
    step(1,0,0,0,0,0);
    chk("nocache_miss0", 0, 0, 0, 1, 32'h0, 0);
    step(1,0,0,0,1,32'h93);
    chk("nocache_fill0", 1, 32'h93, 32'h0, 0, 32'h0, 0);
    for (int k = 0; k < 5; k++) begin
      step(1,1,0,0,0,0);
      chk($sformatf("stall_hold%0d", k), 1, 32'h93, 32'h0, 0, 32'h0, 0);
    end
    step(1,0,0,0,0,0);
    chk("stall_release", 0, 0, 0, 1, 32'h4, 0);
    step(1,0,0,0,1,32'h493);
    chk("nocache_fill4", 1, 32'h493, 32'h4, 0, 32'h4, 0);
    step(1,0,1,32'h80,0,0);
    chk("jump_80", 0, 0, 0, 0, 32'h4, 0);
`endif
    step(1,0,0,0,0,0);
    chk("miss_80", 0, 0, 0, 1, 32'h80, 0);

    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_mid_miss", 0, 32'h0, 32'h0, 0, 32'h0, 1);
    @(posedge clk);
    #1;
    chk("reset_held", 0, 32'h0, 32'h0, 0, 32'h0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1,0,0,0,0,0);
    chk("post_reset_miss0", 0, 0, 0, 1, 32'h0, 0);
    step(1,0,0,0,1,32'h93);
    chk("post_reset_fill0", 1, 32'h93, 32'h0, 0, 32'h0, 0);
    step(1,0,0,0,0,0);
    chk("post_reset_next_req", 0, 0, 0, 1, 32'h4, 0);

    @(negedge clk);
    load_done = 1'b0; jump = 1'b0; stall = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
